// File: rtl/snn_pkg.sv
// snn_pkg: op encoding and saturating add shared by the SNN datapath blocks.
// Consumers import snn_pkg::*.
package snn_pkg;

    localparam int OP_W  = 2;
    localparam int SAT_W = 32;

    typedef enum logic [OP_W-1:0] {
        OP_ACCUM = 2'd0,
        OP_FIRE  = 2'd1,
        OP_CLEAR = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    // Signed a+b clamped to the range of a w-bit signed value (w <= SAT_W).
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             w
    );
        logic signed [SAT_W:0] s;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        s  = $signed({a[SAT_W-1], a}) + $signed({b[SAT_W-1], b});
        hi = $signed((SAT_W+1)'(1) << (w - 1)) - $signed((SAT_W+1)'(1));
        lo = -hi - $signed((SAT_W+1)'(1));
        if (s > hi) begin
            sat_add = hi[SAT_W-1:0];
        end else if (s < lo) begin
            sat_add = lo[SAT_W-1:0];
        end else begin
            sat_add = s[SAT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/lif_adder_tree.sv
// lif_adder_tree: gated signed sum of N_IN spike/weight lanes.
// Combinational; the result is wide enough that it can never overflow.
module lif_adder_tree #(
    parameter  int N_IN = 4,
    parameter  int W_W  = 8,
    localparam int SW   = W_W + $clog2(N_IN)
) (
    input  logic [N_IN-1:0]     spike,
    input  logic [N_IN*W_W-1:0] weight,
    output logic signed [SW-1:0] sum
);

    // Each lane contributes its sign-extended weight only when its spike is set.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (spike[i]) begin
                sum = sum + SW'($signed(weight[i*W_W +: W_W]));
            end
        end
    end

endmodule

// File: rtl/lif_pe.sv
// lif_pe: leaky integrate-and-fire PE, N_LAYER membranes, 2-stage pipeline.
// Optional refractory counters are built when LIF_REFRACTORY_EN is defined.
module lif_pe
    import snn_pkg::*;
#(
    parameter  int N_IN    = 4,
    parameter  int W_W     = 8,
    parameter  int V_W     = 16,
    parameter  int N_LAYER = 2,
    parameter  int REFRAC  = 2,
    localparam int LW      = $clog2(N_LAYER)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W-1:0]        in_op,
    input  logic [LW-1:0]          in_layer,
    input  logic [N_IN-1:0]        spike_in,
    input  logic [N_IN*W_W-1:0]    weight_in,
    input  logic signed [V_W-1:0]  threshold,
    input  logic [V_W-1:0]         leak,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_spike,
    output logic [LW-1:0]          out_layer,
    output logic signed [V_W-1:0]  out_vmem
);

    localparam int SW = W_W + $clog2(N_IN);

    logic                  adv;
    logic                  in_ok;
    logic signed [SW-1:0]  tree_sum;

    logic                  s1_valid_q, s1_valid_d;
    op_e                   s1_op_q, s1_op_d;
    logic [LW-1:0]         s1_layer_q, s1_layer_d;
    logic signed [V_W-1:0] s1_sum_q, s1_sum_d;

    logic signed [V_W-1:0] v_q [N_LAYER];
    logic signed [V_W-1:0] v_d [N_LAYER];

    logic                  out_valid_q, out_valid_d;
    logic                  out_spike_q, out_spike_d;
    logic [LW-1:0]         out_layer_q, out_layer_d;
    logic signed [V_W-1:0] out_vmem_q, out_vmem_d;

    logic signed [V_W-1:0] v_cur;
    logic signed [V_W-1:0] v_acc;
    logic signed [V_W-1:0] v_leak;
    logic signed [V_W:0]   v_wide;
    logic [V_W:0]          mag;
    logic [V_W:0]          lk;
    logic                  fire_hit;
    logic                  ref_active;

    // The whole pipeline moves only when the output slot is free or draining.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // Reserved ops and out-of-range layers are accepted but never enter S1.
    assign in_ok = in_valid
                && (op_e'(in_op) != OP_RSVD)
                && (32'(in_layer) < N_LAYER);

    lif_adder_tree #(
        .N_IN (N_IN),
        .W_W  (W_W)
    ) u_tree (
        .spike  (spike_in),
        .weight (weight_in),
        .sum    (tree_sum)
    );

    assign v_cur    = v_q[s1_layer_q];
    assign v_acc    = V_W'(sat_add(SAT_W'(v_cur), SAT_W'(s1_sum_q), V_W));
    assign fire_hit = (v_cur >= threshold);

`ifdef LIF_REFRACTORY_EN
    localparam int RW = $clog2(REFRAC + 2);

    logic [RW-1:0] ref_q [N_LAYER];
    logic [RW-1:0] ref_d [N_LAYER];

    assign ref_active = (ref_q[s1_layer_q] != '0);
`else
    // A negative refractory length is meaningless; this folds to 0.
    assign ref_active = (REFRAC < 0);
`endif

    // Leak moves the membrane toward zero by at most leak, never past it.
    always_comb begin
        v_wide = {v_cur[V_W-1], v_cur};
        lk     = {1'b0, leak};
        mag    = '0;
        v_leak = '0;
        if (v_cur[V_W-1]) begin
            mag = -v_wide;
            if (mag > lk) begin
                v_leak = V_W'(v_wide + $signed(lk));
            end
        end else if (v_cur != '0) begin
            mag = v_wide;
            if (mag > lk) begin
                v_leak = V_W'(v_wide - $signed(lk));
            end
        end
    end

    // S1 next state: capture the op and its gated weight sum when advancing.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_layer_d = s1_layer_q;
        s1_sum_d   = s1_sum_q;
        if (adv) begin
            s1_valid_d = in_ok;
            s1_op_d    = op_e'(in_op);
            s1_layer_d = in_layer;
            s1_sum_d   = V_W'(tree_sum);
        end
    end

    // S2: apply the S1 op to its membrane and load the FIRE result.
    always_comb begin
        v_d         = v_q;
        out_valid_d = out_valid_q;
        out_spike_d = out_spike_q;
        out_layer_d = out_layer_q;
        out_vmem_d  = out_vmem_q;
`ifdef LIF_REFRACTORY_EN
        ref_d       = ref_q;
`endif
        if (adv) begin
            out_valid_d = 1'b0;
            if (s1_valid_q) begin
                case (s1_op_q)
                    OP_ACCUM: begin
                        if (!ref_active) begin
                            v_d[s1_layer_q] = v_acc;
                        end
                    end
                    OP_FIRE: begin
                        out_valid_d = 1'b1;
                        out_layer_d = s1_layer_q;
                        out_vmem_d  = v_cur;
                        out_spike_d = 1'b0;
                        if (ref_active) begin
`ifdef LIF_REFRACTORY_EN
                            ref_d[s1_layer_q] = ref_q[s1_layer_q] - RW'(1);
`endif
                        end else if (fire_hit) begin
                            out_spike_d     = 1'b1;
                            v_d[s1_layer_q] = '0;
`ifdef LIF_REFRACTORY_EN
                            ref_d[s1_layer_q] = RW'(REFRAC);
`endif
                        end else begin
                            v_d[s1_layer_q] = v_leak;
                        end
                    end
                    OP_CLEAR: begin
                        v_d[s1_layer_q] = '0;
`ifdef LIF_REFRACTORY_EN
                        ref_d[s1_layer_q] = '0;
`endif
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_ACCUM;
            s1_layer_q  <= '0;
            s1_sum_q    <= '0;
            out_valid_q <= 1'b0;
            out_spike_q <= 1'b0;
            out_layer_q <= '0;
            out_vmem_q  <= '0;
            for (int i = 0; i < N_LAYER; i++) begin
                v_q[i] <= '0;
`ifdef LIF_REFRACTORY_EN
                ref_q[i] <= '0;
`endif
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_layer_q  <= s1_layer_d;
            s1_sum_q    <= s1_sum_d;
            out_valid_q <= out_valid_d;
            out_spike_q <= out_spike_d;
            out_layer_q <= out_layer_d;
            out_vmem_q  <= out_vmem_d;
            for (int i = 0; i < N_LAYER; i++) begin
                v_q[i] <= v_d[i];
`ifdef LIF_REFRACTORY_EN
                ref_q[i] <= ref_d[i];
`endif
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_spike = out_spike_q;
    assign out_layer = out_layer_q;
    assign out_vmem  = out_vmem_q;

endmodule
